// File: rtl/ps2mouse_rx_ext_pkg.sv
// Shared PS/2 mouse definitions: frame length, byte0 field positions,
// frame/packet state encodings and the movement-delta decoder.
package ps2_defs;

  localparam int FRAME_LEN = 11;
  localparam int DATA_BITS = FRAME_LEN - 3;

  localparam int B0_LEFT   = 0;
  localparam int B0_RIGHT  = 1;
  localparam int B0_MIDDLE = 2;
  localparam int B0_SYNC   = 3;
  localparam int B0_XSIGN  = 4;
  localparam int B0_YSIGN  = 5;
  localparam int B0_XOVF   = 6;
  localparam int B0_YOVF   = 7;

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [2:0] {P_B0, P_B1, P_B2, P_B3, P_APPLY} pkt_state_t;

  // An overflowed axis saturates to the extreme 9-bit value in its direction.
  function automatic logic [8:0] decode_delta(input logic sign, input logic ovf,
                                              input logic [7:0] mag);
    if (ovf) return sign ? 9'h100 : 9'h0FF;
    return {sign, mag};
  endfunction

endpackage

// File: rtl/ps2mouse_rx_ext_if.sv
// Mouse state bus from the receiver to the register block.
interface ps2mouse_rx_ext_if #(parameter int POS_W = 16);
  logic             oTrig;
  logic             oErr;
  logic [POS_W-1:0] Xpos;
  logic [POS_W-1:0] Ypos;
  logic [POS_W-1:0] Zpos;
  logic [4:0]       key_down;

  modport master (output oTrig, oErr, Xpos, Ypos, Zpos, key_down);
  modport slave  (input  oTrig, oErr, Xpos, Ypos, Zpos, key_down);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronise, deglitch the clock,
// shift in start/data/parity/stop and flag bad or stalled frames.
module ps2_frame_rx
  import ps2_defs::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
      if (clk_s2 == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt_clk <= clk_s2;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // The cycle in which the filtered clock commits to low is the sample point.
  assign fall = filt_clk && !clk_s2 && (flt_cnt == FLT_LAST);
  assign busy = (state != F_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= F_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          F_IDLE: begin
            if (!dat_s2) begin
              state   <= F_DATA;
              bit_cnt <= '0;
            end
          end
          F_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state <= F_PARITY;
          end
          F_PARITY: begin
            if (^{shreg, dat_s2}) begin
              state <= F_STOP;
            end else begin
              frame_err <= 1'b1;
              state     <= F_IDLE;
            end
          end
          F_STOP: begin
            state <= F_IDLE;
            if (dat_s2) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= F_IDLE;
        endcase
      end else if (state != F_IDLE) begin
        if (to_cnt == TO_LAST) begin
          frame_err <= 1'b1;
          state     <= F_IDLE;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2mouse_rx_ext.sv
// PS/2 mouse receiver: packet assembly, inter-byte timeout and the
// clamped position / wheel / button state seen by the register block.
module ps2mouse_rx_ext
  import ps2_defs::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int POS_W       = 16,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int WHEEL_EN    = 0,
  parameter int Y_INVERT    = 1
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               PS2_CLK,
  input  logic               PS2_DAT,
  ps2mouse_rx_ext_if.master  mouse
);

  localparam int EXT = POS_W + 2;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]        TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [POS_W-1:0]     X_TOP   = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]     Y_TOP   = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0]     X_HOME  = POS_W'(X_MAX >> 1);
  localparam logic [POS_W-1:0]     Y_HOME  = POS_W'(Y_MAX >> 1);
  localparam logic signed [EXT-1:0] X_LIM  = EXT'(X_MAX);
  localparam logic signed [EXT-1:0] Y_LIM  = EXT'(Y_MAX);

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err, busy;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame (
    .clk       (CLOCK),
    .rst       (RESET),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  pkt_state_t            state;
  logic [7:0]            b0, b1, b2, cur_b2;
  logic [TW-1:0]         gap_cnt;
  logic [8:0]            dx, dy;
  logic signed [EXT-1:0] x_sum, y_sum;
  logic [POS_W-1:0]      x_new, y_new, z_new;
  logic [4:0]            keys_new;

  // The final byte of a packet is still on rx_byte when the update is registered.
  always_comb begin
    cur_b2 = (state == P_B2) ? rx_byte : b2;
    dx = decode_delta(b0[B0_XSIGN], b0[B0_XOVF], b1);
    dy = decode_delta(b0[B0_YSIGN], b0[B0_YOVF], cur_b2);
    x_sum = $signed({2'b00, mouse.Xpos}) + $signed({{(EXT-9){dx[8]}}, dx});
    if (Y_INVERT != 0) y_sum = $signed({2'b00, mouse.Ypos}) - $signed({{(EXT-9){dy[8]}}, dy});
    else               y_sum = $signed({2'b00, mouse.Ypos}) + $signed({{(EXT-9){dy[8]}}, dy});
    if (x_sum[EXT-1])       x_new = '0;
    else if (x_sum > X_LIM) x_new = X_TOP;
    else                    x_new = x_sum[POS_W-1:0];
    if (y_sum[EXT-1])       y_new = '0;
    else if (y_sum > Y_LIM) y_new = Y_TOP;
    else                    y_new = y_sum[POS_W-1:0];
    if (WHEEL_EN != 0) begin
      z_new    = mouse.Zpos + {{(POS_W-4){rx_byte[3]}}, rx_byte[3:0]};
      keys_new = {rx_byte[5], rx_byte[4], b0[B0_MIDDLE], b0[B0_RIGHT], b0[B0_LEFT]};
    end else begin
      z_new    = mouse.Zpos;
      keys_new = {2'b00, b0[B0_MIDDLE], b0[B0_RIGHT], b0[B0_LEFT]};
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state          <= P_B0;
      b0             <= '0;
      b1             <= '0;
      b2             <= '0;
      gap_cnt        <= '0;
      mouse.oTrig    <= 1'b0;
      mouse.oErr     <= 1'b0;
      mouse.Xpos     <= X_HOME;
      mouse.Ypos     <= Y_HOME;
      mouse.Zpos     <= '0;
      mouse.key_down <= '0;
    end else begin
      mouse.oTrig <= 1'b0;
      mouse.oErr  <= 1'b0;
      if (frame_err) begin
        state      <= P_B0;
        gap_cnt    <= '0;
        mouse.oErr <= 1'b1;
      end else if (byte_valid) begin
        gap_cnt <= '0;
        case (state)
          P_B1: begin
            b1    <= rx_byte;
            state <= P_B2;
          end
          P_B2: begin
            b2 <= rx_byte;
            if (WHEEL_EN != 0) begin
              state <= P_B3;
            end else begin
              state          <= P_APPLY;
              mouse.oTrig    <= 1'b1;
              mouse.Xpos     <= x_new;
              mouse.Ypos     <= y_new;
              mouse.Zpos     <= z_new;
              mouse.key_down <= keys_new;
            end
          end
          P_B3: begin
            state          <= P_APPLY;
            mouse.oTrig    <= 1'b1;
            mouse.Xpos     <= x_new;
            mouse.Ypos     <= y_new;
            mouse.Zpos     <= z_new;
            mouse.key_down <= keys_new;
          end
          default: begin
            if (rx_byte[B0_SYNC]) begin
              b0    <= rx_byte;
              state <= P_B1;
            end else begin
              mouse.oErr <= 1'b1;
              state      <= P_B0;
            end
          end
        endcase
      end else if (state == P_B0 || state == P_APPLY || busy) begin
        // While a frame is in flight the frame receiver owns the timeout.
        gap_cnt <= '0;
        if (state == P_APPLY) state <= P_B0;
      end else if (gap_cnt == TO_LAST) begin
        mouse.oErr <= 1'b1;
        state      <= P_B0;
        gap_cnt    <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule
